// File: rtl/ccu_mu_arbiter.sv
// ccu_mu_arbiter: round-robin memory-unit arbiter with grant lock and sticky write-back/access pairing
package ccu_mu_pkg;
  typedef enum logic [1:0] {
    SEND_AXI_REQ_R,
    SEND_AXI_REQ_W,
    SEND_AXI_REQ_WRITE_BACK_R,
    SEND_AXI_REQ_WRITE_BACK_W
  } mu_op_e;
endpackage

module ccu_mu_arbiter
  import ccu_mu_pkg::*;
#(
  parameter int NoReqs = 2,
  parameter int MaxHold = 4,
  parameter type payload_t = logic
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic     [NoReqs-1:0]       req_i,
  input  mu_op_e   [NoReqs-1:0]       op_i,
  input  payload_t [NoReqs-1:0]       payload_i,
  input  logic     [NoReqs-1:0]       sticky_i,
  output logic     [NoReqs-1:0]       gnt_o,
  output logic                        mu_req_o,
  output mu_op_e                      mu_op_o,
  output payload_t                    mu_payload_o,
  input  logic                        mu_gnt_i,
  output logic [$clog2(NoReqs)-1:0]   sel_o
);
  localparam int SW = $clog2(NoReqs);
  logic [SW-1:0] rr_q, lock_idx_q, sticky_idx_q, rr_sel, j;
  logic          lock_q, sticky_q, rr_hit, valid, hs;
  logic [3:0]    hold_cnt_q;
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = rr_q;
    j = rr_q;
    for (int k = NoReqs - 1; k >= 0; k--) begin
      j = SW'((int'(rr_q) + k) % NoReqs);
      if (req_i[j]) begin
        rr_hit = 1'b1;
        rr_sel = j;
      end
    end
  end
  assign valid = !rst_i && (lock_q ? req_i[lock_idx_q] : sticky_q ? req_i[sticky_idx_q] : rr_hit);
  assign sel_o = !valid ? rr_q : lock_q ? lock_idx_q : sticky_q ? sticky_idx_q : rr_sel;
  assign mu_req_o = valid;
  assign mu_op_o = valid ? op_i[sel_o] : SEND_AXI_REQ_R;
  assign mu_payload_o = valid ? payload_i[sel_o] : '0;
  assign hs = valid && mu_gnt_i;
  assign gnt_o = hs ? NoReqs'(1) << sel_o : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      sticky_q <= 1'b0;
      sticky_idx_q <= '0;
      hold_cnt_q <= '0;
    end else if (hs) begin
      rr_q <= (int'(sel_o) == NoReqs - 1) ? '0 : sel_o + 1'b1;
      lock_q <= 1'b0;
      sticky_q <= sticky_i[sel_o];
      sticky_idx_q <= sel_o;
      hold_cnt_q <= '0;
    end else begin
      if (valid) begin
        lock_q <= 1'b1;
        lock_idx_q <= sel_o;
      end else if (lock_q) begin
        lock_q <= 1'b0;
      end
      if (sticky_q && !req_i[sticky_idx_q]) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
        if (int'(hold_cnt_q) + 1 >= MaxHold) sticky_q <= 1'b0;
      end
    end
  end
endmodule
